// File: rtl/card_dealer.sv
// Deals HAND_SIZE distinct LFSR-drawn cards into hand_memory; each accepted draw is written one cycle later.
// A deal occupies the DRAW state until HAND_SIZE accepts have been made. There is no backpressure. Control inputs are ignored outside IDLE.
module card_dealer #(
    parameter int          HAND_SIZE    = 5,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        new_deck,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic        we,
    output logic [2:0]  waddr,
    output logic [5:0]  card_in,
    output logic        busy,
    output logic        done,
    output logic [5:0]  cards_left,
    output logic        deck_empty,
    output logic        start_err
);

    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [5:0]  HS6      = 6'(HAND_SIZE);
    localparam logic [2:0]  LAST_IDX = 3'(HAND_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [51:0] mask_q, mask_d;
    logic [5:0]  left_q, left_d;
    logic [2:0]  idx_q, idx_d;
    logic        we_q, we_d;
    logic [2:0]  waddr_q, waddr_d;
    logic [5:0]  card_q, card_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        empty_q, empty_d;
    logic        err_q, err_d;

    logic [5:0]  cand;
    logic [5:0]  cand_bit;
    logic        cand_ok;
    logic [15:0] lfsr_step;

    // cand_bit is only meaningful for ranks 2..14; cand_ok masks the rest.
    assign cand      = lfsr_q[5:0];
    assign cand_bit  = {4'd0, cand[5:4]} * 6'd13 + {2'd0, cand[3:0]} - 6'd2;
    assign cand_ok   = (cand[3:0] >= 4'd2) && (cand[3:0] <= 4'd14) && !mask_q[cand_bit];
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        mask_d  = mask_q;
        left_d  = left_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        card_d  = card_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // seed, then deck clear, then start: start sees the refreshed count
                if (seed_load) lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
                if (new_deck) begin
                    mask_d = '0;
                    left_d = 6'd52;
                end
                if (start) begin
                    if (left_d >= HS6) begin
                        state_d = S_DRAW;
                        idx_d   = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                lfsr_d = lfsr_step;
                if (cand_ok) begin
                    we_d    = 1'b1;
                    waddr_d = idx_q;
                    card_d  = cand;
                    mask_d  = mask_q | (52'd1 << cand_bit);
                    left_d  = left_q - 6'd1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d == S_DRAW);
        empty_d = (left_d < HS6);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_DEFAULT;
            mask_q  <= '0;
            left_q  <= 6'd52;
            idx_q   <= 3'd0;
            we_q    <= 1'b0;
            waddr_q <= 3'd0;
            card_q  <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            left_q  <= left_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            card_q  <= card_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign card_in    = card_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cards_left = left_q;
    assign deck_empty = empty_q;
    assign start_err  = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: random seeds checked against a deck-level reference model of the deal rules.
module tb_card_dealer;

    localparam int HS      = 5;
    localparam int CYC_MAX = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, new_deck = 1'b0, seed_load = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        we, busy, done, deck_empty, start_err;
    logic [2:0]  waddr;
    logic [5:0]  card_in, cards_left;

    int tests_run = 0;
    int failures  = 0;

    card_dealer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .new_deck(new_deck),
        .seed_load(seed_load), .seed(seed), .we(we), .waddr(waddr),
        .card_in(card_in), .busy(busy), .done(done), .cards_left(cards_left),
        .deck_empty(deck_empty), .start_err(start_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a deck of 52 flags, the generator state, and a count.
    logic [15:0] ref_lfsr;
    bit          ref_used [52];
    int          ref_left;
    logic [5:0]  exp_cards [$];

    // Captured DUT behaviour for one deal.
    logic [5:0]  cap_cards [$];
    int cap_nwe, cap_addr_bad, cap_done, cap_done_last, cap_busy_bad, cap_err, cap_after_bad;
    bit seen [52];
    logic [5:0]  s1_cards [$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic void ref_reset_deck();
        for (int k = 0; k < 52; k++) ref_used[k] = 1'b0;
        ref_left = 52;
    endfunction

    function automatic void ref_seed(input logic [15:0] s);
        ref_lfsr = (s == 16'h0) ? 16'h0001 : s;
    endfunction

    function automatic void ref_deal();
        int got, c, r, s;
        got = 0;
        exp_cards.delete();
        while (got < HS) begin
            c = int'(ref_lfsr[5:0]);
            ref_lfsr = lfsr_next(ref_lfsr);
            r = c % 16;
            s = c / 16;
            if (r >= 2 && r <= 14 && !ref_used[s * 13 + r - 2]) begin
                ref_used[s * 13 + r - 2] = 1'b1;
                exp_cards.push_back(6'(c));
                ref_left--;
                got++;
            end
        end
    endfunction

    function automatic int diff_cards(input logic [5:0] a [$], input logic [5:0] b [$]);
        int n;
        n = (a.size() == b.size()) ? 0 : 1;
        for (int k = 0; k < a.size() && k < b.size(); k++)
            if (a[k] !== b[k]) n++;
        return n;
    endfunction

    // Returns the number of captured cards that are invalid or already seen.
    function automatic int note_cards();
        int n, r, idx;
        n = 0;
        foreach (cap_cards[k]) begin
            r = int'(cap_cards[k][3:0]);
            idx = int'(cap_cards[k][5:4]) * 13 + r - 2;
            if (r < 2 || r > 14) n++;
            else if (seen[idx]) n++;
            else seen[idx] = 1'b1;
        end
        return n;
    endfunction

    function automatic void clear_seen();
        for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    endfunction

    function automatic int seen_count();
        int n;
        n = 0;
        for (int k = 0; k < 52; k++) if (seen[k]) n++;
        return n;
    endfunction

    task automatic pulse_idle(input bit ld, input logic [15:0] sd, input bit nd);
        seed_load = ld; seed = sd; new_deck = nd;
        @(negedge clk);
        seed_load = 1'b0; new_deck = 1'b0;
    endtask

    // Starts a deal (optionally with seed/deck controls in the same cycle) and records what the DUT does.
    task automatic do_deal(input bit ld, input logic [15:0] sd, input bit nd, input int poke);
        cap_cards.delete();
        cap_nwe = 0; cap_addr_bad = 0; cap_done = 0; cap_done_last = 0;
        cap_busy_bad = 0; cap_err = 0; cap_after_bad = 0;
        start = 1'b1; seed_load = ld; seed = sd; new_deck = nd;
        for (int i = 1; i <= CYC_MAX; i++) begin
            @(negedge clk);
            start = 1'b0; seed_load = 1'b0; new_deck = 1'b0;
            if (i == poke) begin
                start = 1'b1; seed_load = 1'b1; new_deck = 1'b1; seed = 16'($urandom);
            end
            if (start_err) cap_err++;
            if (we) begin
                if (waddr !== 3'(cap_nwe)) cap_addr_bad++;
                cap_cards.push_back(card_in);
                cap_nwe++;
            end
            if (done) begin
                cap_done++;
                if (we && cap_nwe == HS) cap_done_last = 1;
                if (busy) cap_busy_bad++;
                break;
            end else if (!busy) begin
                cap_busy_bad++;
            end
        end
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0; new_deck = 1'b0;
        if (we || done || busy) cap_after_bad = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", we); end
        tests_run++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (start_err !== 1'b0) begin failures++; $display("FAIL reset_start_err: got %b want 0", start_err); end
        tests_run++; if (cards_left !== 6'd52) begin failures++; $display("FAIL reset_cards_left: got %0d want 52", cards_left); end
        tests_run++; if (deck_empty !== 1'b0) begin failures++; $display("FAIL reset_deck_empty: got %b want 0", deck_empty); end
        tests_run++; if (waddr !== 3'd0 || card_in !== 6'd0) begin failures++; $display("FAIL reset_data: got waddr %0d card %0d want 0 0", waddr, card_in); end
        rst_n = 1'b1;
        @(negedge clk);
        ref_seed(16'hACE1);
        ref_reset_deck();
    endtask

    task automatic test_initial_deal();
        pulse_idle(1'b1, 16'hACE1, 1'b0);
        pulse_idle(1'b0, 16'h0, 1'b1);
        ref_seed(16'hACE1); ref_reset_deck(); ref_deal();
        clear_seen();
        do_deal(1'b0, 16'h0, 1'b0, 0);
        s1_cards = cap_cards;
        tests_run++; if (cap_nwe != HS) begin failures++; $display("FAIL deal1_writes: got %0d want %0d", cap_nwe, HS); end
        tests_run++; if (cap_addr_bad != 0) begin failures++; $display("FAIL deal1_waddr_order: got %0d bad want 0", cap_addr_bad); end
        tests_run++; if (note_cards() != 0) begin failures++; $display("FAIL deal1_distinct_valid: got repeat/invalid want none"); end
        tests_run++; if (diff_cards(cap_cards, exp_cards) != 0) begin failures++; $display("FAIL deal1_cards: got %p want %p", cap_cards, exp_cards); end
        tests_run++; if (cap_done != 1 || cap_done_last != 1) begin failures++; $display("FAIL deal1_done: got count %0d with_last_we %0d want 1 1", cap_done, cap_done_last); end
        tests_run++; if (cap_busy_bad != 0 || cap_after_bad != 0) begin failures++; $display("FAIL deal1_busy: got %0d/%0d bad want 0/0", cap_busy_bad, cap_after_bad); end
        tests_run++; if (cards_left !== 6'd47) begin failures++; $display("FAIL deal1_cards_left: got %0d want 47", cards_left); end
    endtask

    task automatic test_exhaustion();
        int bad;
        bad = 0;
        pulse_idle(1'b0, 16'h0, 1'b1);
        ref_reset_deck(); clear_seen();
        for (int h = 0; h < 10; h++) begin
            ref_deal();
            do_deal(1'b0, 16'h0, 1'b0, 0);
            bad += note_cards() + diff_cards(cap_cards, exp_cards) + (cap_done == 1 ? 0 : 1);
        end
        tests_run++; if (bad != 0) begin failures++; $display("FAIL exhaust_hands: got %0d bad cards/deals want 0", bad); end
        tests_run++; if (seen_count() != 50) begin failures++; $display("FAIL exhaust_distinct: got %0d want 50", seen_count()); end
        tests_run++; if (cards_left !== 6'd2) begin failures++; $display("FAIL exhaust_cards_left: got %0d want 2", cards_left); end
        tests_run++; if (deck_empty !== 1'b1) begin failures++; $display("FAIL exhaust_deck_empty: got %b want 1", deck_empty); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++; if (start_err !== 1'b1 || we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL exhaust_start_err: got err %b we %b busy %b want 1 0 0", start_err, we, busy); end
        @(negedge clk);
        tests_run++; if (start_err !== 1'b0 || we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL exhaust_err_pulse: got err %b we %b busy %b want 0 0 0", start_err, we, busy); end
        pulse_idle(1'b0, 16'h0, 1'b1);
        ref_reset_deck(); ref_deal();
        do_deal(1'b0, 16'h0, 1'b0, 0);
        tests_run++; if (diff_cards(cap_cards, exp_cards) != 0 || cards_left !== 6'd47) begin failures++; $display("FAIL exhaust_redeal: got left %0d cards %p want 47 %p", cards_left, cap_cards, exp_cards); end
    endtask

    task automatic test_reset_mid_deal();
        int nwe, ndone;
        nwe = 0; ndone = 0;
        start = 1'b1;
        for (int i = 0; i < CYC_MAX && nwe < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (we) nwe++;
            if (done) ndone++;
        end
        rst_n = 1'b0;
        #1;
        tests_run++; if (nwe != 2) begin failures++; $display("FAIL midrst_reach: got %0d writes want 2", nwe); end
        tests_run++; if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ndone != 0) begin failures++; $display("FAIL midrst_outputs: got we %b busy %b done %b dones %0d want 0 0 0 0", we, busy, done, ndone); end
        tests_run++; if (cards_left !== 6'd52) begin failures++; $display("FAIL midrst_cards_left: got %0d want 52", cards_left); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ref_seed(16'hACE1); ref_reset_deck(); ref_deal();
        do_deal(1'b0, 16'h0, 1'b0, 0);
        tests_run++; if (diff_cards(cap_cards, s1_cards) != 0) begin failures++; $display("FAIL midrst_replay: got %p want %p", cap_cards, s1_cards); end
    endtask

    task automatic test_start_while_busy();
        int left_before;
        left_before = ref_left;
        ref_deal();
        do_deal(1'b0, 16'h0, 1'b0, 2);
        tests_run++; if (cap_nwe != HS || cap_done != 1) begin failures++; $display("FAIL busy_ignore_count: got writes %0d dones %0d want %0d 1", cap_nwe, cap_done, HS); end
        tests_run++; if (diff_cards(cap_cards, exp_cards) != 0) begin failures++; $display("FAIL busy_ignore_cards: got %p want %p", cap_cards, exp_cards); end
        tests_run++; if (int'(cards_left) != left_before - HS || cap_after_bad != 0) begin failures++; $display("FAIL busy_ignore_left: got %0d want %0d", cards_left, left_before - HS); end
    endtask

    task automatic test_seed_zero();
        logic [5:0] first [$];
        logic [15:0] rs;
        pulse_idle(1'b1, 16'h0, 1'b1);
        ref_seed(16'h0); ref_reset_deck(); ref_deal();
        do_deal(1'b0, 16'h0, 1'b0, 0);
        first = cap_cards;
        tests_run++; if (diff_cards(cap_cards, exp_cards) != 0 || cap_done != 1) begin failures++; $display("FAIL seed0_deal: got %p want %p", cap_cards, exp_cards); end
        pulse_idle(1'b1, 16'h0, 1'b1);
        do_deal(1'b0, 16'h0, 1'b0, 0);
        tests_run++; if (diff_cards(cap_cards, first) != 0) begin failures++; $display("FAIL seed0_repeat: got %p want %p", cap_cards, first); end
        rs = 16'($urandom);
        pulse_idle(1'b1, rs, 1'b1);
        ref_seed(rs); ref_reset_deck(); ref_deal();
        do_deal(1'b0, 16'h0, 1'b0, 0);
        first = cap_cards;
        pulse_idle(1'b1, rs, 1'b1);
        do_deal(1'b0, 16'h0, 1'b0, 0);
        tests_run++; if (diff_cards(first, exp_cards) != 0 || diff_cards(cap_cards, first) != 0) begin failures++; $display("FAIL seed_repeat: seed %h got %p then %p want %p", rs, first, cap_cards, exp_cards); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] rs;
        pulse_idle(1'b0, 16'h0, 1'b1);
        ref_reset_deck();
        for (int h = 0; h < 10; h++) begin
            ref_deal();
            do_deal(1'b0, 16'h0, 1'b0, 0);
        end
        tests_run++; if (cards_left !== 6'd2) begin failures++; $display("FAIL simul_pre_left: got %0d want 2", cards_left); end
        rs = 16'($urandom);
        ref_seed(rs); ref_reset_deck(); ref_deal();
        do_deal(1'b1, rs, 1'b1, 0);
        tests_run++; if (cap_err != 0) begin failures++; $display("FAIL simul_no_err: got %0d start_err pulses want 0", cap_err); end
        tests_run++; if (diff_cards(cap_cards, exp_cards) != 0 || cap_done != 1) begin failures++; $display("FAIL simul_seed_first: seed %h got %p want %p", rs, cap_cards, exp_cards); end
        tests_run++; if (cards_left !== 6'd47 || deck_empty !== 1'b0) begin failures++; $display("FAIL simul_left: got %0d empty %b want 47 0", cards_left, deck_empty); end
    endtask

    initial begin
        test_reset();
        test_initial_deal();
        test_exhaustion();
        test_reset_mid_deal();
        test_start_while_busy();
        test_seed_zero();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
